// File: rtl/me_result_collector_pkg.sv
// Shared definitions for the motion-estimation result collector: field widths,
// result-entry layout and the frame-tracking FSM state type.
package me_result_collector_pkg;

  localparam int MV_WIDTH        = 6;
  localparam int BLK_IDX_WIDTH   = 8;
  localparam int ENTRY_TAG_WIDTH = 2 * MV_WIDTH + 2 * BLK_IDX_WIDTH;

  // Tag field offsets measured from the top of the MSAD field (MSAD sits in the LSBs)
  localparam int MV_X_OFS  = 0;
  localparam int MV_Y_OFS  = MV_WIDTH;
  localparam int BLK_X_OFS = 2 * MV_WIDTH;
  localparam int BLK_Y_OFS = 2 * MV_WIDTH + BLK_IDX_WIDTH;

  function automatic int entry_width(input int sad_w);
    return sad_w + ENTRY_TAG_WIDTH;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACC,
    ST_DONE
  } coll_state_t;

endpackage

// File: rtl/me_result_fifo.sv
// Synchronous show-ahead FIFO: the head entry is always presented on rd_data,
// and push is honoured on a full FIFO only when a pop retires the head in the same cycle.
module me_result_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             rd_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == DEPTH_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/me_result_collector.sv
// Collects ME results on data_valid rising edges, converts coordinates to signed
// motion vectors, tags block position, queues entries and totals SAD per frame.
module me_result_collector
  import me_result_collector_pkg::*;
#(
  parameter int SAD_BIT_WIDTH   = 14,
  parameter int SEARCH_OFFSET   = 8,
  parameter int BLOCKS_PER_ROW  = 4,
  parameter int BLOCKS_PER_COL  = 4,
  parameter int FIFO_DEPTH      = 4,
  parameter int FRAME_SAD_WIDTH = 20
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [SAD_BIT_WIDTH-1:0]   MSAD,
  input  logic [4:0]                 MSAD_column,
  input  logic [4:0]                 MSAD_row,
  input  logic                       data_valid,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [SAD_BIT_WIDTH-1:0]   res_msad,
  output logic [5:0]                 res_mv_x,
  output logic [5:0]                 res_mv_y,
  output logic [7:0]                 res_blk_x,
  output logic [7:0]                 res_blk_y,
  output logic [FRAME_SAD_WIDTH-1:0] frame_sad,
  output logic                       frame_done,
  output logic                       overflow
);

  localparam int ENTRY_W = entry_width(SAD_BIT_WIDTH);
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0]         FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [BLK_IDX_WIDTH-1:0] LAST_X   = BLK_IDX_WIDTH'(BLOCKS_PER_ROW - 1);
  localparam logic [BLK_IDX_WIDTH-1:0] LAST_Y   = BLK_IDX_WIDTH'(BLOCKS_PER_COL - 1);
  localparam logic signed [MV_WIDTH-1:0] MV_ZERO = MV_WIDTH'(SEARCH_OFFSET);

  function automatic logic [FRAME_SAD_WIDTH-1:0] sat_add(
    input logic [FRAME_SAD_WIDTH-1:0] a,
    input logic [SAD_BIT_WIDTH-1:0]   b
  );
    logic [FRAME_SAD_WIDTH:0] sum;
    sum = {1'b0, a} + (FRAME_SAD_WIDTH + 1)'(b);
    return sum[FRAME_SAD_WIDTH] ? '1 : sum[FRAME_SAD_WIDTH-1:0];
  endfunction

  function automatic logic signed [MV_WIDTH-1:0] coord_to_mv(input logic [4:0] coord);
    return $signed({1'b0, coord}) - MV_ZERO;
  endfunction

  logic                           data_valid_q;
  logic                           cap;
  logic                           pop;
  logic                           push;
  logic                           drop;
  logic                           frame_end;
  logic [BLK_IDX_WIDTH-1:0]       blk_x;
  logic [BLK_IDX_WIDTH-1:0]       blk_y;
  logic [FRAME_SAD_WIDTH-1:0]     acc;
  logic [FRAME_SAD_WIDTH-1:0]     acc_next;
  coll_state_t                    state;
  logic signed [MV_WIDTH-1:0]     mv_x_p0;
  logic signed [MV_WIDTH-1:0]     mv_y_p0;
  logic [ENTRY_W-1:0]             entry_p0;
  logic [ENTRY_W-1:0]             head_p1;
  logic                           fifo_full;
  logic                           fifo_empty;
  logic [CNT_W-1:0]               fifo_count;

  // Stage p0: capture-cycle entry formed straight from the ME inputs
  assign cap       = data_valid & ~data_valid_q;
  assign pop       = res_valid & res_ready;
  assign push      = cap & ((fifo_count != FULL_CNT) | pop);
  assign drop      = cap & fifo_full & ~pop;
  assign frame_end = (blk_x == LAST_X) & (blk_y == LAST_Y);
  assign acc_next  = sat_add(acc, MSAD);
  assign mv_x_p0   = coord_to_mv(MSAD_column);
  assign mv_y_p0   = coord_to_mv(MSAD_row);
  assign entry_p0  = {blk_y, blk_x, mv_y_p0, mv_x_p0, MSAD};

  me_result_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (entry_p0),
    .pop     (pop),
    .rd_data (head_p1),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Stage p1: FIFO head, forced to zero while nothing is queued
  assign res_valid = ~fifo_empty;
  assign res_msad  = res_valid ? head_p1[SAD_BIT_WIDTH-1:0] : '0;
  assign res_mv_x  = res_valid ? head_p1[SAD_BIT_WIDTH+MV_X_OFS  +: MV_WIDTH]      : '0;
  assign res_mv_y  = res_valid ? head_p1[SAD_BIT_WIDTH+MV_Y_OFS  +: MV_WIDTH]      : '0;
  assign res_blk_x = res_valid ? head_p1[SAD_BIT_WIDTH+BLK_X_OFS +: BLK_IDX_WIDTH] : '0;
  assign res_blk_y = res_valid ? head_p1[SAD_BIT_WIDTH+BLK_Y_OFS +: BLK_IDX_WIDTH] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_valid_q <= 1'b0;
      blk_x        <= '0;
      blk_y        <= '0;
      overflow     <= 1'b0;
    end else begin
      data_valid_q <= data_valid;
      if (drop) overflow <= 1'b1;
      if (cap) begin
        if (blk_x == LAST_X) begin
          blk_x <= '0;
          blk_y <= (blk_y == LAST_Y) ? '0 : blk_y + 1'b1;
        end else begin
          blk_x <= blk_x + 1'b1;
        end
      end
    end
  end

  // A cap seen in DONE behaves exactly like one seen in IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      acc        <= '0;
      frame_sad  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (cap && frame_end) begin
        frame_sad  <= acc_next;
        acc        <= '0;
        frame_done <= 1'b1;
        state      <= ST_DONE;
      end else if (cap) begin
        acc   <= acc_next;
        state <= ST_ACC;
      end else if (state == ST_DONE) begin
        state <= ST_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_me_result_collector.sv
// Scoreboard bench for me_result_collector: the driver predicts entries and frame
// totals from block counts and queue occupancy; a negedge monitor checks outputs.
module tb_me_result_collector;

  localparam int SADW  = 14;
  localparam int OFS   = 8;
  localparam int BPR   = 4;
  localparam int BPC   = 4;
  localparam int DEPTH = 4;
  localparam int FSW   = 17;
  localparam longint SAT = (64'd1 << FSW) - 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [SADW-1:0] MSAD = '0;
  logic [4:0]      MSAD_column = '0;
  logic [4:0]      MSAD_row = '0;
  logic            data_valid = 1'b0;
  logic            res_valid;
  logic            res_ready = 1'b0;
  logic [SADW-1:0] res_msad;
  logic [5:0]      res_mv_x;
  logic [5:0]      res_mv_y;
  logic [7:0]      res_blk_x;
  logic [7:0]      res_blk_y;
  logic [FSW-1:0]  frame_sad;
  logic            frame_done;
  logic            overflow;

  always #5 clk = ~clk;

  me_result_collector #(
    .SAD_BIT_WIDTH   (SADW),
    .SEARCH_OFFSET   (OFS),
    .BLOCKS_PER_ROW  (BPR),
    .BLOCKS_PER_COL  (BPC),
    .FIFO_DEPTH      (DEPTH),
    .FRAME_SAD_WIDTH (FSW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .MSAD        (MSAD),
    .MSAD_column (MSAD_column),
    .MSAD_row    (MSAD_row),
    .data_valid  (data_valid),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_msad    (res_msad),
    .res_mv_x    (res_mv_x),
    .res_mv_y    (res_mv_y),
    .res_blk_x   (res_blk_x),
    .res_blk_y   (res_blk_y),
    .frame_sad   (frame_sad),
    .frame_done  (frame_done),
    .overflow    (overflow)
  );

  typedef struct {
    int msad;
    int mvx;
    int mvy;
    int bx;
    int by;
  } exp_t;

  exp_t   exp_q[$];
  int     cyc = 0;
  int     n_chk = 0;
  int     n_pass = 0;
  bit     prev_dv = 0;
  bit     pushed_now = 0;
  int     caps = 0;
  longint acc_m = 0;
  longint pend_fsad = 0;
  longint exp_fsad = 0;
  int     fd_cycle = -10;
  int     ovf_cycle = 1 << 30;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Drive one cycle of inputs and update the reference model for it
  task automatic step(input bit dv, input int msad, input int col, input int row, input bit rdy);
    @(posedge clk);
    #1;
    data_valid  = dv;
    MSAD        = SADW'(msad);
    MSAD_column = 5'(col);
    MSAD_row    = 5'(row);
    res_ready   = rdy;
    pushed_now  = 0;
    if (dv && !prev_dv) begin
      exp_t e;
      bit   popping;
      popping = rdy && (exp_q.size() > 0);
      e.msad = msad;
      e.mvx  = col - OFS;
      e.mvy  = row - OFS;
      e.bx   = caps % BPR;
      e.by   = (caps / BPR) % BPC;
      if (exp_q.size() < DEPTH || popping) begin
        exp_q.push_back(e);
        pushed_now = 1;
      end else if (ovf_cycle > cyc + 1) begin
        ovf_cycle = cyc + 1;
      end
      caps++;
      acc_m = (acc_m + msad > SAT) ? SAT : acc_m + msad;
      if (caps % (BPR * BPC) == 0) begin
        pend_fsad = acc_m;
        acc_m     = 0;
        fd_cycle  = cyc + 1;
      end
    end
    prev_dv = dv;
  endtask

  task automatic cap1(input int msad, input int col, input int row, input bit rdy);
    step(1, msad, col, row, rdy);
    step(0, 0, 0, 0, rdy);
  endtask

  task automatic idle(input int n, input bit rdy);
    repeat (n) step(0, 0, 0, 0, rdy);
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clk);
    #1;
    rst        = 1'b1;
    data_valid = 1'b0;
    res_ready  = 1'b0;
    exp_q.delete();
    prev_dv    = 0;
    pushed_now = 0;
    caps       = 0;
    acc_m      = 0;
    pend_fsad  = 0;
    exp_fsad   = 0;
    fd_cycle   = -10;
    ovf_cycle  = 1 << 30;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_outputs",
          {res_valid, res_msad, res_mv_x, res_mv_y, res_blk_x, res_blk_y, frame_sad, frame_done, overflow},
          0);
  endtask

  // Monitor: compare DUT outputs against the scoreboard away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      check("res_valid", res_valid, exp_q.size() > (pushed_now ? 1 : 0));
      if (res_valid && res_ready && exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("res_msad", res_msad, e.msad);
        check("res_mv_x", $signed(res_mv_x), e.mvx);
        check("res_mv_y", $signed(res_mv_y), e.mvy);
        check("res_blk_x", res_blk_x, e.bx);
        check("res_blk_y", res_blk_y, e.by);
      end
      check("frame_done", frame_done, cyc == fd_cycle);
      if (cyc == fd_cycle) exp_fsad = pend_fsad;
      check("frame_sad", frame_sad, exp_fsad);
      check("overflow", overflow, cyc >= ovf_cycle);
    end
  end

  initial begin
    do_reset(2);

    // Single block with data_valid held, then a negative/positive MV pair
    repeat (3) step(1, 100, 8, 8, 0);
    idle(2, 0);
    idle(2, 1);
    cap1(50, 0, 15, 1);
    idle(2, 1);

    // Full frame drained continuously, plus one cap to see the wrap to (0,0)
    do_reset(2);
    repeat (16) cap1(10, 8, 8, 1);
    cap1(10, 8, 8, 1);
    idle(3, 1);

    // Backpressure: two of six results dropped, then the frame completes
    do_reset(2);
    repeat (6) cap1($urandom_range(0, 16383), $urandom_range(0, 31), $urandom_range(0, 31), 0);
    idle(8, 1);
    repeat (10) cap1($urandom_range(0, 16383), $urandom_range(0, 31), $urandom_range(0, 31), 1);
    idle(3, 1);

    // Full FIFO with a cap and a pop in the same cycle
    do_reset(2);
    repeat (4) cap1($urandom_range(0, 16383), $urandom_range(0, 31), $urandom_range(0, 31), 0);
    step(1, 777, 3, 20, 1);
    step(0, 0, 0, 0, 0);
    idle(8, 1);

    // Saturating frame total, then reset in the middle of a frame
    do_reset(2);
    repeat (16) cap1(16383, 8, 8, 1);
    idle(3, 1);
    repeat (5) cap1(1234, 1, 2, 0);
    do_reset(3);
    cap1(42, 9, 7, 1);
    idle(3, 1);

    // Randomized traffic with random backpressure
    do_reset(2);
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 2) != 0, $urandom_range(0, 16383), $urandom_range(0, 31),
           $urandom_range(0, 31), $urandom_range(0, 3) != 0);
    end
    idle(DEPTH + 4, 1);
    check("drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
